// File: rtl/capsule_pkg.sv
// Shared constants, types and FSM encoding for the capsule motion block.
package capsule_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int CAP_W    = 64;
   localparam int CAP_H    = 32;
   localparam int POS_W    = 10;
   localparam int X0       = 288;
   localparam int Y0       = 224;

   typedef logic [POS_W-1:0] pos_t;
   typedef logic [2:0]       speed_t;

   localparam pos_t X_MAX = pos_t'(SCREEN_W - CAP_W);
   localparam pos_t Y_MAX = pos_t'(SCREEN_H - CAP_H);

   typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, DONE} state_t;

endpackage

// File: rtl/capsule_motion_if.sv
// Frame-control, speed and position/pulse bundle between the frame timer,
// the motion stage and the renderer.
interface capsule_motion_if;
   import capsule_pkg::*;

   logic   frame_start;
   logic   pause;
   speed_t speed_x;
   speed_t speed_y;
   pos_t   pos_x;
   pos_t   pos_y;
   logic   bounce_x;
   logic   bounce_y;
   logic   corner;
   logic   busy;
   logic   update_done;

   modport master (
      output frame_start, pause, speed_x, speed_y,
      input  pos_x, pos_y, bounce_x, bounce_y, corner, busy, update_done
   );

   modport slave (
      input  frame_start, pause, speed_x, speed_y,
      output pos_x, pos_y, bounce_x, bounce_y, corner, busy, update_done
   );

endinterface

// File: rtl/capsule_axis_step.sv
// One-axis constant-speed step with wall bounce; shared by both axes.
module capsule_axis_step
   import capsule_pkg::*;
(
   input  pos_t   pos,
   input  logic   dir_neg,
   input  speed_t speed,
   input  pos_t   limit,
   output pos_t   nxt_pos,
   output logic   nxt_dir_neg,
   output logic   hit
);

   logic [POS_W:0] nx;

   always_comb begin
      nx          = dir_neg ? ({1'b0, pos} - {{(POS_W-2){1'b0}}, speed})
                            : ({1'b0, pos} + {{(POS_W-2){1'b0}}, speed});
      nxt_pos     = nx[POS_W-1:0];
      nxt_dir_neg = dir_neg;
      hit         = 1'b0;
      // A zero speed never bounces, so a capsule parked on a wall stays put.
      if (speed != '0) begin
         if (!dir_neg && (nx >= {1'b0, limit})) begin
            nxt_pos     = limit;
            nxt_dir_neg = 1'b1;
            hit         = 1'b1;
         end else if (dir_neg && (pos <= pos_t'(speed))) begin
            nxt_pos     = '0;
            nxt_dir_neg = 1'b0;
            hit         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/capsule_motion.sv
// Per-frame capsule position update with edge bounce.
// Optional CAPSULE_GRAVITY_EN replaces constant y motion with a falling velocity.
module capsule_motion
   import capsule_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   capsule_motion_if.slave bus
);

   state_t state, state_nxt;
   pos_t   pos_x, pos_y;
   logic   dir_x_neg;
   logic   hit_x_seen, hit_y_seen;
   logic   go;

   pos_t   ax_pos, ax_limit, ax_nxt_pos;
   logic   ax_dir_neg, ax_nxt_dir_neg, ax_hit;
   speed_t ax_speed;
   pos_t   y_nxt;
   logic   y_hit;

   assign go = (state == IDLE) && bus.frame_start && !bus.pause;

   capsule_axis_step u_axis_step (
      .pos         (ax_pos),
      .dir_neg     (ax_dir_neg),
      .speed       (ax_speed),
      .limit       (ax_limit),
      .nxt_pos     (ax_nxt_pos),
      .nxt_dir_neg (ax_nxt_dir_neg),
      .hit         (ax_hit)
   );

`ifdef CAPSULE_GRAVITY_EN
   typedef logic signed [4:0] vel_t;
   vel_t                    vel_y, vel_inc, vel_nxt;
   logic signed [POS_W+1:0] ny;

   function automatic vel_t sat_inc(input vel_t v);
      return (v >= 5'sd7) ? 5'sd7 : v + 5'sd1;
   endfunction

   always_comb begin
      ax_pos     = pos_x;
      ax_dir_neg = dir_x_neg;
      ax_speed   = bus.speed_x;
      ax_limit   = X_MAX;
   end

   always_comb begin
      vel_inc = sat_inc(vel_y);
      ny      = $signed({2'b00, pos_y}) + $signed({{(POS_W-3){vel_inc[4]}}, vel_inc});
      y_hit   = 1'b1;
      if (ny >= $signed({2'b00, Y_MAX})) begin
         y_nxt   = Y_MAX;
         vel_nxt = -$signed({2'b00, bus.speed_y});
      end else if (ny[POS_W+1] || (ny == '0)) begin
         y_nxt   = '0;
         vel_nxt = '0;
      end else begin
         y_nxt   = ny[POS_W-1:0];
         vel_nxt = vel_inc;
         y_hit   = 1'b0;
      end
   end
`else
   logic dir_y_neg;

   // The single step unit serves x in STEP_X and y in STEP_Y.
   always_comb begin
      ax_pos     = pos_x;
      ax_dir_neg = dir_x_neg;
      ax_speed   = bus.speed_x;
      ax_limit   = X_MAX;
      if (state == STEP_Y) begin
         ax_pos     = pos_y;
         ax_dir_neg = dir_y_neg;
         ax_speed   = bus.speed_y;
         ax_limit   = Y_MAX;
      end
   end

   assign y_nxt = ax_nxt_pos;
   assign y_hit = ax_hit;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = STEP_X;
         STEP_X:  state_nxt = STEP_Y;
         STEP_Y:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy        = (state != IDLE);
      bus.update_done = (state == DONE);
      bus.corner      = (state == DONE) && hit_x_seen && hit_y_seen;
      bus.bounce_x    = (state == STEP_X) && ax_hit;
      bus.bounce_y    = (state == STEP_Y) && y_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_x      <= pos_t'(X0);
         pos_y      <= pos_t'(Y0);
         dir_x_neg  <= 1'b0;
         hit_x_seen <= 1'b0;
         hit_y_seen <= 1'b0;
`ifdef CAPSULE_GRAVITY_EN
         vel_y      <= '0;
`else
         dir_y_neg  <= 1'b0;
`endif
      end else begin
         case (state)
            STEP_X: begin
               pos_x      <= ax_nxt_pos;
               dir_x_neg  <= ax_nxt_dir_neg;
               hit_x_seen <= ax_hit;
            end
            STEP_Y: begin
               pos_y      <= y_nxt;
               hit_y_seen <= y_hit;
`ifdef CAPSULE_GRAVITY_EN
               vel_y      <= vel_nxt;
`else
               dir_y_neg  <= ax_nxt_dir_neg;
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.pos_x = pos_x;
   assign bus.pos_y = pos_y;

endmodule

// File: tb/tb_capsule_motion.sv
// Directed bench for capsule_motion: vector table plus multi-cycle corner cases.
module tb_capsule_motion;
   import capsule_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   capsule_motion_if bus ();

   capsule_motion dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      int px1; int py2; int bx_x; int by_x; int bx_y; int by_y;
      int cn;  int dn;  int busy_d; int busy_after;
   } frame_res_t;

   typedef struct {
      int sx; int sy; int ex; int ey; int ebx; int eby; int ecn;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Called at a negedge; returns at the negedge one cycle after the FSM is idle again.
   task automatic do_frame(input int sx, input int sy, output frame_res_t r);
      bus.speed_x     = 3'(sx);
      bus.speed_y     = 3'(sy);
      bus.frame_start = 1'b1;
      @(posedge clk);
      #1 bus.frame_start = 1'b0;
      @(negedge clk);
      r.bx_x = int'(bus.bounce_x);
      r.by_x = int'(bus.bounce_y);
      @(negedge clk);
      r.px1  = int'(bus.pos_x);
      r.bx_y = int'(bus.bounce_x);
      r.by_y = int'(bus.bounce_y);
      @(negedge clk);
      r.py2    = int'(bus.pos_y);
      r.cn     = int'(bus.corner);
      r.dn     = int'(bus.update_done);
      r.busy_d = int'(bus.busy);
      @(negedge clk);
      r.busy_after = int'(bus.busy);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      frame_res_t r;
      vec_t       vecs [4];
      int         cnt;

      vecs[0] = '{3, 3, 291, 227, 0, 0, 0};
      vecs[1] = '{0, 0, 291, 227, 0, 0, 0};
      vecs[2] = '{7, 5, 298, 232, 0, 0, 0};
      vecs[3] = '{1, 7, 299, 239, 0, 0, 0};

      rst_n           = 1'b0;
      bus.frame_start = 1'b0;
      bus.pause       = 1'b0;
      bus.speed_x     = '0;
      bus.speed_y     = '0;
      repeat (2) @(negedge clk);
      check("rst_pos_x", int'(bus.pos_x), 288);
      check("rst_pos_y", int'(bus.pos_y), 224);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_pulses", int'(bus.update_done) + int'(bus.bounce_x) + int'(bus.bounce_y) + int'(bus.corner), 0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef CAPSULE_GRAVITY_EN
      begin
         int vel = 0;
         int y   = 224;
         int eb;
         for (int f = 1; f <= 36; f++) begin
            eb  = 0;
            vel = (vel >= 7) ? 7 : vel + 1;
            y   = y + vel;
            if (y >= 448) begin
               y = 448; vel = -6; eb = 1;
            end else if (y <= 0) begin
               y = 0; vel = 0; eb = 1;
            end
            do_frame(0, 6, r);
            check($sformatf("grav_y_f%0d", f), r.py2, y);
            check($sformatf("grav_by_f%0d", f), r.by_y, eb);
         end
      end
`else
      for (int i = 0; i < 4; i++) begin
         do_frame(vecs[i].sx, vecs[i].sy, r);
         check($sformatf("vec%0d_pos_x", i), r.px1, vecs[i].ex);
         check($sformatf("vec%0d_pos_y", i), r.py2, vecs[i].ey);
         check($sformatf("vec%0d_bounce_x", i), r.bx_x, vecs[i].ebx);
         check($sformatf("vec%0d_bounce_y", i), r.by_y, vecs[i].eby);
         check($sformatf("vec%0d_corner", i), r.cn, vecs[i].ecn);
         check($sformatf("vec%0d_done", i), r.dn, 1);
         if (i == 0) begin
            check("lat_busy_done", r.busy_d, 1);
            check("lat_busy_fall", r.busy_after, 0);
         end
      end

      // pause: frame_start pulses must be ignored entirely
      bus.pause = 1'b1;
      cnt = 0;
      repeat (5) begin
         bus.frame_start = 1'b1;
         @(posedge clk);
         #1 bus.frame_start = 1'b0;
         repeat (3) begin
            @(negedge clk);
            cnt += int'(bus.busy);
         end
      end
      bus.pause = 1'b0;
      check("pause_busy", cnt, 0);
      check("pause_pos_x", int'(bus.pos_x), 299);
      check("pause_pos_y", int'(bus.pos_y), 239);

      // frame_start held into STEP_X must not queue a second update
      bus.speed_x     = 3'd1;
      bus.speed_y     = 3'd0;
      bus.frame_start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 bus.frame_start = 1'b0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         cnt += int'(bus.update_done);
      end
      check("dbl_done_cnt", cnt, 1);
      check("dbl_pos_x", int'(bus.pos_x), 300);
      check("dbl_pos_y", int'(bus.pos_y), 239);
      check("dbl_busy", int'(bus.busy), 0);

      // reset during STEP_Y
      bus.speed_x     = 3'd3;
      bus.speed_y     = 3'd3;
      bus.frame_start = 1'b1;
      @(posedge clk);
      #1 bus.frame_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_pos_x_before", int'(bus.pos_x), 303);
      rst_n = 1'b0;
      #1;
      check("mid_rst_pos_x", int'(bus.pos_x), 288);
      check("mid_rst_pos_y", int'(bus.pos_y), 224);
      check("mid_rst_busy", int'(bus.busy), 0);
      check("mid_rst_bounce_y", int'(bus.bounce_y), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         cnt += int'(bus.update_done) + int'(bus.bounce_x) + int'(bus.bounce_y) + int'(bus.corner);
      end
      check("mid_no_pulses", cnt, 0);
      check("mid_after_pos_y", int'(bus.pos_y), 224);

      // right wall: 72 frames at speed 4 from x=288
      cnt = 0;
      for (int f = 1; f <= 72; f++) begin
         do_frame(4, 0, r);
         if (f < 72) cnt += r.bx_x + r.by_y;
      end
      check("wall_early_bounce", cnt, 0);
      check("wall_pos_x", r.px1, 576);
      check("wall_bounce_x", r.bx_x, 1);
      check("wall_bounce_y", r.by_y, 0);
      do_frame(0, 0, r);
      check("wall_spd0_pos_x", r.px1, 576);
      check("wall_spd0_bounce", r.bx_x, 0);
      do_frame(4, 0, r);
      check("wall_back_pos_x", r.px1, 572);
      check("wall_back_pos_y", r.py2, 224);
      check("wall_back_bounce", r.bx_x, 0);

      // corner: (352,224) then 56 diagonal frames reaches (576,448) together
      pulse_reset();
      for (int f = 0; f < 16; f++) do_frame(4, 0, r);
      cnt = 0;
      for (int f = 1; f <= 56; f++) begin
         do_frame(4, 4, r);
         if (f < 56) cnt += r.cn + r.bx_x + r.by_y;
      end
      check("corner_early", cnt, 0);
      check("corner_pos_x", r.px1, 576);
      check("corner_pos_y", r.py2, 448);
      check("corner_bx_in_step_x", r.bx_x, 1);
      check("corner_by_in_step_x", r.by_x, 0);
      check("corner_by_in_step_y", r.by_y, 1);
      check("corner_bx_in_step_y", r.bx_y, 0);
      check("corner_pulse", r.cn, 1);
      check("corner_done", r.dn, 1);
      do_frame(4, 4, r);
      check("corner_next_x", r.px1, 572);
      check("corner_next_y", r.py2, 444);
      check("corner_next_pulse", r.cn, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
